pe_feed_ctrl: RTL and testbench

//  Sequencer driving the PE accumulate array; the issuing end of its alu_start / cycle_num / sram_rdata interface.
//  Per tile: issues K_STEPS weight-column reads and K_STEPS vector-element reads to the SRAMs.

---
 rtl/pe_feed_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_pe_feed_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_feed_ctrl.sv
// pe_feed_ctrl: tile sequencer for the PE accumulate array.
// For each tile it streams K_STEPS weight-column reads and K_STEPS vector
// reads, then drives alu_start/cycle_num so that they line up with the SRAM
// read data (1-cycle latency) arriving at the PE. Every output is a flop.
module pe_feed_ctrl #(
  parameter int K_STEPS = 32,
  parameter int ADDR_W  = 10,
  parameter int TILE_W  = 8
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic              start,
  input  logic              abort,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] v_base,
  input  logic [ADDR_W-1:0] w_stride,
  input  logic [ADDR_W-1:0] v_stride,
  output logic              busy,
  output logic              tile_done,
  output logic              done,
  output logic [TILE_W-1:0] tile_idx,
  output logic              sram_ren_w,
  output logic [ADDR_W-1:0] sram_raddr_w,
  output logic              sram_ren_v,
  output logic [ADDR_W-1:0] sram_raddr_v,
  output logic              alu_start,
  output logic [8:0]        cycle_num
);

  // In-tile cycle counter: c0..c(K+1) are spent in RUN, c(K+2) is TDONE.
  localparam logic [8:0] CNT_K    = 9'(K_STEPS);
  localparam logic [8:0] CNT_LAST = 9'(K_STEPS + 1);
  localparam logic [8:0] PRIME_CN = 9'h1FF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_TDONE = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [TILE_W-1:0] tile_idx_q, tile_idx_d;

  // Job parameters captured at accept; pure data, no reset needed.
  logic [TILE_W-1:0] num_tiles_q, num_tiles_d;
  logic [ADDR_W-1:0] w_stride_q, w_stride_d;
  logic [ADDR_W-1:0] v_stride_q, v_stride_d;
  logic [ADDR_W-1:0] w_tile_q, w_tile_d;   // w_base + t*w_stride
  logic [ADDR_W-1:0] v_tile_q, v_tile_d;   // v_base + t*v_stride

  logic              busy_q, busy_d;
  logic              tile_done_q, tile_done_d;
  logic              done_q, done_d;
  logic              ren_w_q, ren_w_d;
  logic [ADDR_W-1:0] raddr_w_q, raddr_w_d;
  logic              ren_v_q, ren_v_d;
  logic [ADDR_W-1:0] raddr_v_q, raddr_v_d;
  logic              alu_start_q, alu_start_d;
  logic [8:0]        cycle_num_q, cycle_num_d;

  logic              more_tiles;

  // Widened by one bit so num_tiles at its maximum value cannot overflow.
  assign more_tiles = ({1'b0, tile_idx_q} + (TILE_W + 1)'(1)) < {1'b0, num_tiles_q};

  // Next-state logic; outputs for the upcoming cycle are derived from the
  // chosen next state and in-tile count so they come straight out of flops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tile_idx_d  = tile_idx_q;
    num_tiles_d = num_tiles_q;
    w_stride_d  = w_stride_q;
    v_stride_d  = v_stride_q;
    w_tile_d    = w_tile_q;
    v_tile_d    = v_tile_q;
    busy_d      = busy_q;
    tile_done_d = 1'b0;
    done_d      = 1'b0;
    ren_w_d     = 1'b0;
    raddr_w_d   = raddr_w_q;
    ren_v_d     = 1'b0;
    raddr_v_d   = raddr_v_q;
    alu_start_d = 1'b0;
    cycle_num_d = 9'd0;

    unique case (state_q)
      S_IDLE: begin
        busy_d     = 1'b0;
        tile_idx_d = '0;
        // abort is deliberately not looked at here: it only cancels live jobs.
        if (start) begin
          num_tiles_d = num_tiles;
          w_stride_d  = w_stride;
          v_stride_d  = v_stride;
          w_tile_d    = w_base;
          v_tile_d    = v_base;
          cnt_d       = 9'd0;
          if (num_tiles == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          tile_idx_d = '0;
          cnt_d      = 9'd0;
          raddr_w_d  = '0;
          raddr_v_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_TDONE;
          tile_done_d = 1'b1;
          cnt_d       = 9'd0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      S_TDONE: begin
        if (abort) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          tile_idx_d = '0;
          raddr_w_d  = '0;
          raddr_v_d  = '0;
        end else if (more_tiles) begin
          state_d    = S_RUN;
          cnt_d      = 9'd0;
          tile_idx_d = tile_idx_q + TILE_W'(1);
          w_tile_d   = w_tile_q + w_stride_q;
          v_tile_d   = v_tile_q + v_stride_q;
        end else begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end
      end

      S_FIN: begin
        state_d    = S_IDLE;
        busy_d     = 1'b0;
        tile_idx_d = '0;
        if (abort) begin
          raddr_w_d = '0;
          raddr_v_d = '0;
        end
      end

      default: begin
        state_d    = S_IDLE;
        busy_d     = 1'b0;
        tile_idx_d = '0;
      end
    endcase

    // Tile timeline: weights read at c0..c(K-1), vectors at c1..cK (one
    // behind so data pairs up at the PE), PE enabled c1..c(K+1) with c1 as
    // the priming step that only loads weight 0.
    if (state_d == S_RUN) begin
      ren_w_d = (cnt_d < CNT_K);
      if (ren_w_d) begin
        raddr_w_d = w_tile_d + ADDR_W'(cnt_d);
      end
      ren_v_d = (cnt_d >= 9'd1) && (cnt_d <= CNT_K);
      if (ren_v_d) begin
        raddr_v_d = v_tile_d + ADDR_W'(cnt_d - 9'd1);
      end
      alu_start_d = (cnt_d >= 9'd1) && (cnt_d <= CNT_LAST);
      if (cnt_d == 9'd1) begin
        cycle_num_d = PRIME_CN;
      end else if (alu_start_d) begin
        cycle_num_d = cnt_d - 9'd2;
      end
    end
  end

  // Control state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 9'd0;
      tile_idx_q  <= '0;
      busy_q      <= 1'b0;
      tile_done_q <= 1'b0;
      done_q      <= 1'b0;
      ren_w_q     <= 1'b0;
      raddr_w_q   <= '0;
      ren_v_q     <= 1'b0;
      raddr_v_q   <= '0;
      alu_start_q <= 1'b0;
      cycle_num_q <= 9'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tile_idx_q  <= tile_idx_d;
      busy_q      <= busy_d;
      tile_done_q <= tile_done_d;
      done_q      <= done_d;
      ren_w_q     <= ren_w_d;
      raddr_w_q   <= raddr_w_d;
      ren_v_q     <= ren_v_d;
      raddr_v_q   <= raddr_v_d;
      alu_start_q <= alu_start_d;
      cycle_num_q <= cycle_num_d;
    end
  end

  // Job parameters and per-tile base addresses; only read while busy.
  always_ff @(posedge clk) begin
    num_tiles_q <= num_tiles_d;
    w_stride_q  <= w_stride_d;
    v_stride_q  <= v_stride_d;
    w_tile_q    <= w_tile_d;
    v_tile_q    <= v_tile_d;
  end

  assign busy         = busy_q;
  assign tile_done    = tile_done_q;
  assign done         = done_q;
  assign tile_idx     = tile_idx_q;
  assign sram_ren_w   = ren_w_q;
  assign sram_raddr_w = raddr_w_q;
  assign sram_ren_v   = ren_v_q;
  assign sram_raddr_v = raddr_v_q;
  assign alu_start    = alu_start_q;
  assign cycle_num    = cycle_num_q;

endmodule

// File: tb/tb_pe_feed_ctrl.sv
// Testbench for pe_feed_ctrl: expected per-cycle output traces are built
// from the tile timeline rules and compared against the DUT every cycle.
module tb_pe_feed_ctrl;

  localparam int K  = 4;
  localparam int AW = 10;
  localparam int TW = 8;

  logic          clk;
  logic          srstn;
  logic          start;
  logic          abort;
  logic [TW-1:0] num_tiles;
  logic [AW-1:0] w_base, v_base, w_stride, v_stride;
  logic          busy, tile_done, done;
  logic [TW-1:0] tile_idx;
  logic          sram_ren_w, sram_ren_v;
  logic [AW-1:0] sram_raddr_w, sram_raddr_v;
  logic          alu_start;
  logic [8:0]    cycle_num;

  typedef struct packed {
    logic          busy;
    logic          tile_done;
    logic          done;
    logic [TW-1:0] tile_idx;
    logic          ren_w;
    logic [AW-1:0] raddr_w;
    logic          ren_v;
    logic [AW-1:0] raddr_v;
    logic          alu_start;
    logic [8:0]    cycle_num;
  } out_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  out_t          exp_q[$];
  logic [AW-1:0] last_w = '0;
  logic [AW-1:0] last_v = '0;

  pe_feed_ctrl #(.K_STEPS(K), .ADDR_W(AW), .TILE_W(TW)) dut (
    .clk(clk), .srstn(srstn), .start(start), .abort(abort),
    .num_tiles(num_tiles), .w_base(w_base), .v_base(v_base),
    .w_stride(w_stride), .v_stride(v_stride),
    .busy(busy), .tile_done(tile_done), .done(done), .tile_idx(tile_idx),
    .sram_ren_w(sram_ren_w), .sram_raddr_w(sram_raddr_w),
    .sram_ren_v(sram_ren_v), .sram_raddr_v(sram_raddr_v),
    .alu_start(alu_start), .cycle_num(cycle_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t dut_out();
    out_t o;
    o.busy      = busy;
    o.tile_done = tile_done;
    o.done      = done;
    o.tile_idx  = tile_idx;
    o.ren_w     = sram_ren_w;
    o.raddr_w   = sram_raddr_w;
    o.ren_v     = sram_ren_v;
    o.raddr_v   = sram_raddr_v;
    o.alu_start = alu_start;
    o.cycle_num = cycle_num;
    return o;
  endfunction

  // Expected trace from cycle E+1 until the block is idle again.
  task automatic build_job(input int nt, input int wb, input int vb, input int ws, input int vs);
    out_t e;
    if (nt == 0) begin
      e = '0; e.done = 1'b1; e.raddr_w = last_w; e.raddr_v = last_v;
      exp_q.push_back(e);
    end else begin
      for (int t = 0; t < nt; t++) begin
        for (int c = 0; c <= K + 2; c++) begin
          e = '0;
          e.busy     = 1'b1;
          e.tile_idx = TW'(t);
          if (c < K) begin
            e.ren_w = 1'b1;
            last_w  = AW'((wb + t * ws + c) % (1 << AW));
          end
          if (c >= 1 && c <= K) begin
            e.ren_v = 1'b1;
            last_v  = AW'((vb + t * vs + c - 1) % (1 << AW));
          end
          e.raddr_w = last_w;
          e.raddr_v = last_v;
          if (c >= 1 && c <= K + 1) begin
            e.alu_start = 1'b1;
            e.cycle_num = (c == 1) ? 9'h1FF : 9'(c - 2);
          end
          e.tile_done = (c == K + 2);
          exp_q.push_back(e);
        end
      end
      e = '0; e.busy = 1'b1; e.done = 1'b1; e.tile_idx = TW'(nt - 1);
      e.raddr_w = last_w; e.raddr_v = last_v;
      exp_q.push_back(e);
    end
    e = '0; e.raddr_w = last_w; e.raddr_v = last_v;
    exp_q.push_back(e);
  endtask

  // Launch a job at the current negedge and check every following cycle.
  task automatic run_job(input string name, input int nt, input int wb, input int vb,
                         input int ws, input int vs, input int abort_at,
                         input int restart_at, input bit abort_with_start);
    out_t e, got;
    exp_q.delete();
    build_job(nt, wb, vb, ws, vs);
    if (abort_at >= 0 && abort_at < exp_q.size() - 1) begin
      while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
      last_w = '0;
      last_v = '0;
      e = '0;
      exp_q.push_back(e);
    end
    start     = 1'b1;
    abort     = abort_with_start;
    num_tiles = TW'(nt);
    w_base    = AW'(wb);
    v_base    = AW'(vb);
    w_stride  = AW'(ws);
    v_stride  = AW'(vs);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        num_tiles = TW'($urandom);
        w_base    = AW'($urandom);
        v_base    = AW'($urandom);
        w_stride  = AW'($urandom);
        v_stride  = AW'($urandom);
      end
      got = dut_out();
      n_tests++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cyc%0d got busy=%b td=%b dn=%b ti=%0d rw=%b aw=%h rv=%b av=%h alu=%b cn=%h | exp busy=%b td=%b dn=%b ti=%0d rw=%b aw=%h rv=%b av=%h alu=%b cn=%h",
                 name, i, got.busy, got.tile_done, got.done, got.tile_idx, got.ren_w, got.raddr_w,
                 got.ren_v, got.raddr_v, got.alu_start, got.cycle_num,
                 exp_q[i].busy, exp_q[i].tile_done, exp_q[i].done, exp_q[i].tile_idx, exp_q[i].ren_w,
                 exp_q[i].raddr_w, exp_q[i].ren_v, exp_q[i].raddr_v, exp_q[i].alu_start, exp_q[i].cycle_num);
      end
      abort = (i == abort_at);
      start = (i == restart_at);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    out_t got;
    got = dut_out();
    n_tests++;
    if (got !== out_t'('0)) begin
      n_fail++;
      $display("FAIL %s got outputs=%h required=0", name, got);
    end
  endtask

  task automatic test_reset();
    srstn = 1'b0; start = 1'b0; abort = 1'b0; num_tiles = '0;
    w_base = '0; v_base = '0; w_stride = '0; v_stride = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    srstn = 1'b1;
    last_w = '0; last_v = '0;
    @(negedge clk);
    check_all_zero("reset_idle");
  endtask

  task automatic test_single_tile();
    run_job("t1_single", 1, 'h10, 'h20, $urandom_range(1023, 0), $urandom_range(1023, 0), -1, -1, 1'b0);
  endtask

  task automatic test_multi_tile();
    run_job("t2_multi", 3, 'h10, 'h20, 'h40, 0, -1, -1, 1'b0);
  endtask

  task automatic test_addr_wrap();
    run_job("t3_wrap", 2, 'h3FE, 'h3FF, 'h3FC, 'h1, -1, -1, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_job("t4_busy_start", 2, 'h55, 'h1A0, 'h8, 'h10, -1, 5, 1'b0);
    run_job("t4_fin_start", 1, 'h77, 'h88, 0, 0, -1, K + 2, 1'b0);
  endtask

  task automatic test_abort();
    run_job("t5_abort", 3, 'h100, 'h200, 'h20, 'h30, (K + 3) + 3, -1, 1'b0);
    run_job("t5_after", 1, 'h0C, 'h0D, 0, 0, -1, -1, 1'b0);
    run_job("abort_tdone", 2, 'h30, 'h31, 'h5, 'h6, K + 1, -1, 1'b0);
    run_job("abort_idle", 1, 'h2A, 'h2B, 0, 0, -1, -1, 1'b1);
  endtask

  task automatic test_async_reset();
    start = 1'b1; abort = 1'b0; num_tiles = 8'd2;
    w_base = 10'h111; v_base = 10'h222; w_stride = 10'h4; v_stride = 10'h4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 srstn = 1'b0;
    #1 check_all_zero("t6_async_reset");
    @(negedge clk);
    check_all_zero("t6_held");
    srstn = 1'b1;
    last_w = '0; last_v = '0;
    run_job("t6_zero_tiles", 0, 'h123, 'h321, 1, 1, -1, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      run_job("rand", int'($urandom_range(3, 0)), int'($urandom_range(1023, 0)),
              int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)),
              int'($urandom_range(1023, 0)), -1, (j % 2 == 1) ? 3 : -1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    run_job("b2b_a", 1, 'h40, 'h50, 0, 0, -1, -1, 1'b0);
    run_job("b2b_b", 2, 'h60, 'h70, 'h3, 'h7, -1, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_addr_wrap();
    test_start_while_busy();
    test_abort();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
